// File: rtl/aer_event_packetizer.sv
// AER 4-phase receiver: synchronizes req, timestamps each event into a FWFT FIFO, streams it valid/ready.
// ack rises 2 clk after synced req; full FIFO (no same-cycle pop) drops the event but ack is still issued.
module aer_event_packetizer #(
  parameter int ROW_W = 2,
  parameter int COL_W = 2,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  localparam int PKT_W = TS_W + 1 + ROW_W + COL_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [ROW_W-1:0] row_addr,
  input  logic [COL_W-1:0] col_addr,
  input  logic             on,
  output logic             ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data,
  output logic [AW:0]      level,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [1:0] {IDLE, PUSH, WAIT_LO} state_t;

  state_t           state, state_nxt;
  logic             req_m, req_s;
  logic [TS_W-1:0]  ts;
  logic [PKT_W-1:0] pkt;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic [7:0]       drops;
  logic             ack_r, ack_nxt;
  logic             full, pop, push, do_latch, do_drop;

  assign full = (cnt == (AW+1)'(DEPTH));
  assign pop  = (cnt != '0) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
      ts    <= '0;
    end else begin
      req_m <= req;
      req_s <= req_m;
      ts    <= ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ack_r <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_r <= ack_nxt;
    end
  end

  // ack only changes on the PUSH and WAIT_LO exits, so it is stable while IDLE
  always_comb begin
    state_nxt = state;
    ack_nxt   = ack_r;
    do_latch  = 1'b0;
    push      = 1'b0;
    do_drop   = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) begin
          do_latch  = 1'b1;
          state_nxt = PUSH;
        end
      end
      PUSH: begin
        push      = !full || pop;
        do_drop   = full && !pop;
        ack_nxt   = 1'b1;
        state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!req_s) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_latch) pkt <= {ts, on, row_addr, col_addr};
    if (push)     mem[wr_ptr] <= pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      drops  <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (do_drop && drops != 8'hFF) drops <= drops + 8'd1;
    end
  end

  assign ack       = ack_r;
  assign out_valid = (cnt != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = cnt;
  assign drop_cnt  = drops;

endmodule

// File: tb/tb_aer_event_packetizer.sv
// Bench for aer_event_packetizer: directed handshakes plus random traffic against a queue-based model.
module tb_aer_event_packetizer;
  localparam int ROW_W = 2;
  localparam int COL_W = 2;
  localparam int TS_W  = 4;
  localparam int DEPTH = 8;
  localparam int PKT_W = TS_W + 1 + ROW_W + COL_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [ROW_W-1:0] row_addr = '0;
  logic [COL_W-1:0] col_addr = '0;
  logic             on = 1'b0;
  logic             ack;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PKT_W-1:0] out_data;
  logic [3:0]       level;
  logic [7:0]       drop_cnt;

  aer_event_packetizer #(.ROW_W(ROW_W), .COL_W(COL_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .row_addr(row_addr), .col_addr(col_addr), .on(on),
    .ack(ack), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tcnt;
  int model_drop = 0;
  int n;
  logic prev_ack = 1'b0;
  logic [PKT_W-1:0] pending = '0;
  logic [PKT_W-1:0] model_q[$];

  // Reference free-running timestamp: clock edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 0;
    else        tcnt <= tcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model update and checks at negedge, return 1ns after the next posedge
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (ack && !prev_ack) begin
        if (model_q.size() < DEPTH) model_q.push_back(pending);
        else if (model_drop < 255)  model_drop++;
      end
      prev_ack = ack;
      chk("level", level, model_q.size());
      chk("out_valid", out_valid, (model_q.size() != 0));
      chk("drop_cnt", drop_cnt, model_drop);
      if (out_ready && model_q.size() != 0) begin
        chk("pop_data", out_data, model_q[0]);
        void'(model_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // mode: 0 leave out_ready, 1 pop only on the push edge, 2 random out_ready every cycle
  task automatic finish_hs(input int hold, input int mode);
    int hi;
    n = 0;
    do begin
      if (mode == 1) out_ready = (n == 3);
      if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!ack && n < 20);
    if (mode == 1) out_ready = 1'b0;
    chk("ack_rise_lat", n, 4);
    hi = 0;
    for (int k = 0; k < hold; k++) begin
      if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      tick();
      if (ack) hi++;
    end
    if (hold > 0) chk("ack_hold", hi, hold);
    req = 1'b0;
    n = 0;
    do begin
      if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (ack && n < 20);
    chk("ack_fall_lat", (n >= 2 && n <= 3), 1);
  endtask

  task automatic start_ev(input logic [1:0] r, input logic [1:0] c, input logic o);
    row_addr = r;
    col_addr = c;
    on       = o;
    pending  = {TS_W'(tcnt + 2), o, r, c};
    req      = 1'b1;
  endtask

  task automatic event_hs(input logic [1:0] r, input logic [1:0] c, input logic o,
                          input int hold, input int mode);
    start_ev(r, c, o);
    finish_hs(hold, mode);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    n = 0;
    while (model_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_empty", model_q.size(), 0);
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();

    // Single event with downstream ready
    out_ready = 1'b1;
    event_hs(2'd2, 2'd1, 1'b1, 0, 0);
    repeat (4) tick();

    // Burst fill: 10 handshakes, 8 stored, 2 dropped
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      event_hs(2'(i >> 2), 2'(i), 1'($urandom_range(0, 1)), 0, 0);
    tick();
    chk("burst_level", level, 8);
    chk("burst_drops", drop_cnt, 2);

    // Push and pop on the same edge while full
    event_hs(2'd3, 2'd3, 1'b0, 0, 1);
    tick();
    chk("full_pushpop_level", level, 8);
    chk("full_pushpop_drops", drop_cnt, 2);
    drain();

    // Timestamp wrap: captures at counter 14 and 17 (mod 16)
    n = 0;
    while ((tcnt % 16) != 12 && n < 40) begin tick(); n++; end
    event_hs(2'd1, 2'd0, 1'b1, 0, 0);
    n = 0;
    while ((tcnt % 16) != 15 && n < 40) begin tick(); n++; end
    event_hs(2'd0, 2'd3, 1'b0, 0, 0);
    drain();

    // Long req hold yields one packet; a second pulse yields another
    out_ready = 1'b1;
    event_hs(2'd1, 2'd2, 1'b1, 50, 0);
    event_hs(2'd2, 2'd2, 1'b0, 0, 0);
    drain();

    // Random traffic with random downstream backpressure
    for (int i = 0; i < 12; i++)
      event_hs(2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 5), 2);
    drain();

    // Async reset in WAIT_LO with 3 packets queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) event_hs(2'(i), 2'(3 - i), 1'b1, 0, 0);
    start_ev(2'd3, 2'd0, 1'b1);
    n = 0;
    do begin tick(); n++; end while (!ack && n < 20);
    chk("pre_rst_ack", ack, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", ack, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_level", level, 0);
    model_q.delete();
    model_drop = 0;
    prev_ack = 1'b0;
    req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("post_rst_drops", drop_cnt, 0);

    // Reset released with req still high: captured exactly once
    rst_n = 1'b0;
    prev_ack = 1'b0;
    #1;
    start_ev(2'd2, 2'd3, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    finish_hs(0, 0);
    repeat (4) tick();
    chk("req_high_rst_empty", model_q.size(), 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aer_event_packetizer.md
Name: aer_event_packetizer

Overview:
Clocked AER receiver directly downstream of the pixel-array Arbiter.
- Completes a 4-phase handshake on the Arbiter's asynchronous req.
- Captures the granted row address, column address and ON polarity, tags each event with a free-running timestamp, and buffers it in a FIFO.
- Presents buffered events as a valid/ready packet stream to the link serializer.

Parameters:
ROW_W, 2, row address width (Arbiter RA)
COL_W, 2, column address width (Arbiter CA)
TS_W, 16, timestamp counter width
DEPTH, 8, FIFO entries (power of 2)
PKT_W, TS_W+1+ROW_W+COL_W, packet width (derived, do not override)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  1  Arbiter event request, asynchronous to clk
row_addr  in  ROW_W  granted row (RA), stable while req high
col_addr  in  COL_W  granted column (CA), stable while req high
on  in  1  event polarity (ON), stable while req high
ack  out  1  handshake acknowledge to Arbiter
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
out_data  out  PKT_W  {ts, on, row, col}, ts in MSBs
level  out  log2(DEPTH)+1  FIFO occupancy
drop_cnt  out  8  saturating count of dropped events

Behaviour:
- Reset (async assert, sync release): ack=0, out_valid=0, level=0, drop_cnt=0, ts counter=0, FSM=IDLE, sync flops=0; FIFO contents don't-care.
- req passes a 2-flop synchronizer; req_s denotes the second-stage output.
- ts counter increments every clock and wraps from 2^TS_W-1 to 0.
- FSM:
  - IDLE: if req_s=1, latch row_addr, col_addr, on and current ts; go to PUSH.
  - PUSH (one cycle): if FIFO not full, or full with a pop in the same cycle, write the latched packet. Otherwise drop it and increment drop_cnt, saturating at 255. In both cases set ack<=1 and go to WAIT_LO.
  - WAIT_LO: hold ack=1 until req_s=0; then ack<=0 and return to IDLE.
- Latency: req rising edge -> req_s high in 2 clocks; ack high 2 clocks after req_s high; packet visible at out_valid in the cycle after the write.
- Re-arm: a new req is serviced only after req falls and ack falls (full 4-phase cycle). No event is captured twice for one req pulse.
- FIFO behaviour:
  - First-word-fall-through: out_valid = (level != 0), out_data = head entry.
  - A pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH; level saturates at DEPTH (full).
- Pop on empty is ignored. Push on full without a pop drops the event and never corrupts stored entries.
- ack is registered and glitch-free, and never toggles while FSM=IDLE.
- Reset mid-handshake: ack drops immediately and the FIFO empties. After release, if req is still high, it is treated as a new event (captured once).

Test Plan:
- Single event: out_ready=1; req high with row=2, col=1, on=1 at ts=T. Expect ack high at ~T+4 clocks; out_data={ts=T+2, 1, 2'b10, 2'b01}; one valid beat. Drop req -> ack low 2-3 clocks later.
- Burst fill: out_ready=0; 10 full handshakes, each with distinct addresses. Expect level=8, drop_cnt=2, the first 8 packets stored in order; ack is still issued for all 10.
- Simultaneous push/pop at full: level=8 with out_ready=1 during PUSH. Expect no drop, level stays 8, and ordering is preserved.
- Timestamp wrap: TS_W=4; events captured at counter values 14 and 17 report ts=14 and ts=1.
- Handshake hold: req held high 50 clocks. Expect exactly one packet and ack high until 2-3 clocks after req falls; a second req pulse yields a second packet.
- Async reset during WAIT_LO with 3 packets queued: ack=0 and out_valid=0 immediately. After release with req low, the bench sees no spurious packet and drop_cnt=0.
